// File: rtl/roberto_rx_medidas.sv
// Host-side receiver for the robot's 7O1 distance frames.
// Turns "ddd,ddd,ddd#" into three 3-digit BCD distance registers.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous reset, active low
//   entrada_serial in   UART line from the robot, idle high
//   medida1..3     out  sensor distances, BCD, hundreds in [11:8]
//   medida_valida  out  one-cycle pulse when medida1..3 were just loaded
//   erro_paridade  out  one-cycle pulse on a parity error
//   erro_frame     out  one-cycle pulse on stop-bit or frame-format error
//   db_estado      out  bit-FSM state code (debug)
module roberto_rx_medidas #(
    parameter int TICKS_BIT  = 434,
    parameter int TICKS_HALF = TICKS_BIT / 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida1,
    output logic [11:0] medida2,
    output logic [11:0] medida3,
    output logic        medida_valida,
    output logic        erro_paridade,
    output logic        erro_frame,
    output logic [2:0]  db_estado
);

    localparam int CW = $clog2(TICKS_BIT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARIDADE = 3'd3,
        STOP     = 3'd4
    } state_t;

    // ------------------------------------------------------------
    // Bit level
    // ------------------------------------------------------------
    logic          sync1_q, sync2_q, prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    nbit_q, nbit_d;
    logic [6:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [6:0]    char_q, char_d;
    logic          char_ok_q, char_ok_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    logic tick_half, tick_bit;
    assign tick_half = (cnt_q == CW'(TICKS_HALF - 1));
    assign tick_bit  = (cnt_q == CW'(TICKS_BIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        nbit_d    = nbit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        char_d    = char_q;
        char_ok_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q)
                    state_d = START;
            end
            START: begin
                if (tick_half) begin
                    cnt_d   = '0;
                    nbit_d  = '0;
                    // line back high at mid start bit: glitch, ignore
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[6:1]};
                    nbit_d  = nbit_q + 3'd1;
                    if (nbit_q == 3'd6)
                        state_d = PARIDADE;
                end
            end
            PARIDADE: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    par_d   = sync2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // framing error wins over parity error
                    if (!sync2_q)
                        ferr_d = 1'b1;
                    else if (!(^{shift_q, par_q}))
                        perr_d = 1'b1;
                    else begin
                        char_ok_d = 1'b1;
                        char_d    = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            nbit_q    <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            char_q    <= '0;
            char_ok_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= entrada_serial;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nbit_q    <= nbit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            char_q    <= char_d;
            char_ok_q <= char_ok_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // ------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------
    logic [3:0]       idx_q, idx_d;
    logic             resync_q, resync_d;
    logic [11:0][3:0] sh_q;
    logic [11:0]      m1_q, m2_q, m3_q;
    logic             valida_q, valida_d;
    logic             fperr_q, fperr_d;
    logic             wr, load;

    logic is_digit, is_comma, is_hash;
    logic want_comma, want_hash, want_digit;

    assign is_digit   = (char_q[6:4] == 3'b011) && (char_q[3:0] <= 4'd9);
    assign is_comma   = (char_q == 7'h2C);
    assign is_hash    = (char_q == 7'h23);
    assign want_comma = (idx_q == 4'd3) || (idx_q == 4'd7);
    assign want_hash  = (idx_q == 4'd11);
    assign want_digit = !want_comma && !want_hash;

    always_comb begin
        idx_d    = idx_q;
        resync_d = resync_q;
        valida_d = 1'b0;
        fperr_d  = 1'b0;
        wr       = 1'b0;
        load     = 1'b0;
        if (perr_q || ferr_q) begin
            resync_d = 1'b1;
        end else if (char_ok_q) begin
            if (resync_q) begin
                if (is_hash) begin
                    resync_d = 1'b0;
                    idx_d    = '0;
                end
            end else if (want_digit && is_digit) begin
                wr    = 1'b1;
                idx_d = idx_q + 4'd1;
            end else if (want_comma && is_comma) begin
                idx_d = idx_q + 4'd1;
            end else if (want_hash && is_hash) begin
                load     = 1'b1;
                valida_d = 1'b1;
                idx_d    = '0;
            end else if (is_hash) begin
                // misplaced terminator is itself a resync point
                fperr_d = 1'b1;
                idx_d   = '0;
            end else begin
                fperr_d  = 1'b1;
                resync_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            resync_q <= 1'b0;
            sh_q     <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            m3_q     <= '0;
            valida_q <= 1'b0;
            fperr_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            resync_q <= resync_d;
            valida_q <= valida_d;
            fperr_q  <= fperr_d;
            if (wr)
                sh_q[idx_q] <= char_q[3:0];
            if (load) begin
                m1_q <= {sh_q[0], sh_q[1], sh_q[2]};
                m2_q <= {sh_q[4], sh_q[5], sh_q[6]};
                m3_q <= {sh_q[8], sh_q[9], sh_q[10]};
            end
        end
    end

    assign medida1       = m1_q;
    assign medida2       = m2_q;
    assign medida3       = m3_q;
    assign medida_valida = valida_q;
    assign erro_paridade = perr_q;
    assign erro_frame    = ferr_q | fperr_q;
    assign db_estado     = state_q;

endmodule
